// File: rtl/multi_channel_pwm.sv
// Multi-channel PWM generator. One shared sawtooth or dual-slope carrier feeds
// per-channel comparators; widths and carrier settings are committed at period boundaries.
module multi_channel_pwm #(
    parameter int unsigned BITS     = 11,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dual_slope_en,
    input  logic [BITS-1:0]     compare_max_in,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_chan,
    input  logic [BITS-1:0]     wr_data,
    input  logic [CHANNELS-1:0] ch_enable,
    input  logic [CHANNELS-1:0] ch_invert,
    output logic                period_end,
    output logic [BITS-1:0]     count,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam logic [BITS-1:0] One = {{(BITS-1){1'b0}}, 1'b1};

    logic [BITS-1:0]     count_q, count_d;
    logic                down_q, down_d;
    logic [BITS-1:0]     max_q, max_d;
    logic                mode_q, mode_d;
    logic [BITS-1:0]     shadow_q [CHANNELS];
    logic [BITS-1:0]     shadow_d [CHANNELS];
    logic [BITS-1:0]     active_q [CHANNELS];
    logic [BITS-1:0]     active_d [CHANNELS];
    logic [CHANNELS-1:0] lvl;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                wr_hit;

    // Carrier: period boundary detection and next count/direction.
    always_comb begin
        count_d = count_q;
        down_d  = down_q;
        max_d   = max_q;
        mode_d  = mode_q;
        if (mode_q) begin
            period_end = down_q && (count_q <= One);
        end else begin
            period_end = (count_q >= max_q);
        end

        if (period_end) begin
            count_d = '0;
            down_d  = 1'b0;
            max_d   = compare_max_in;
            mode_d  = dual_slope_en;
        end else if (!mode_q) begin
            count_d = count_q + One;
        end else if (down_q) begin
            count_d = count_q - One;
        end else if (count_q >= max_q) begin
            // Peak: hold the count one extra cycle while turning around.
            down_d = 1'b1;
        end else begin
            count_d = count_q + One;
        end
    end

    // Width buffers; committing from shadow_d gives write-through on a commit cycle.
    always_comb begin
        wr_hit   = wr_en && (32'(wr_chan) < CHANNELS);
        shadow_d = shadow_q;
        if (wr_hit) begin
            shadow_d[wr_chan] = wr_data;
        end
        active_d = period_end ? shadow_d : active_q;
    end

    // Compare: MSB set selects a forced level given by the next bit (inverted).
    always_comb begin
        lvl   = '0;
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (active_q[i][BITS-1]) begin
                lvl[i] = ~active_q[i][BITS-2];
            end else begin
                lvl[i] = (count_q < active_q[i]);
            end
            pwm_d[i] = ch_enable[i] ? (lvl[i] ^ ch_invert[i]) : ch_invert[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= '0;
            down_q   <= 1'b0;
            max_q    <= compare_max_in;
            mode_q   <= dual_slope_en;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            pwm_q    <= '0;
        end else begin
            count_q  <= count_d;
            down_q   <= down_d;
            max_q    <= max_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign count   = count_q;
    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_multi_channel_pwm.sv
// Self-checking bench for multi_channel_pwm (3-channel build so an out-of-range
// channel index exists); expected outputs are queued when stimulus is applied.
module tb_multi_channel_pwm;

    localparam int unsigned BITS = 11;
    localparam int unsigned NCH  = 3;
    localparam int unsigned CHB  = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            dual_slope_en;
    logic [BITS-1:0] compare_max_in;
    logic            wr_en;
    logic [CHB-1:0]  wr_chan;
    logic [BITS-1:0] wr_data;
    logic [NCH-1:0]  ch_enable;
    logic [NCH-1:0]  ch_invert;
    logic            period_end;
    logic [BITS-1:0] count;
    logic [NCH-1:0]  pwm_out;

    int checks = 0;
    int errors = 0;

    logic [NCH-1:0]  sb [$];
    logic [BITS-1:0] model_w [NCH];

    always #5 clk = ~clk;

    multi_channel_pwm #(
        .BITS     (BITS),
        .CHANNELS (NCH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dual_slope_en  (dual_slope_en),
        .compare_max_in (compare_max_in),
        .wr_en          (wr_en),
        .wr_chan        (wr_chan),
        .wr_data        (wr_data),
        .ch_enable      (ch_enable),
        .ch_invert      (ch_invert),
        .period_end     (period_end),
        .count          (count),
        .pwm_out        (pwm_out)
    );

    // Reference compare rule applied to the bench's own record of active widths.
    function automatic logic [NCH-1:0] exp_pwm(input logic [BITS-1:0] c);
        logic [NCH-1:0] r;
        logic           l;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (model_w[i][BITS-1]) l = ~model_w[i][BITS-2];
            else                    l = (c < model_w[i]);
            r[i] = ch_enable[i] ? (l ^ ch_invert[i]) : ch_invert[i];
        end
        return r;
    endfunction

    task automatic apply_reset(input logic [BITS-1:0] m, input logic mode);
        reset_n        = 1'b0;
        compare_max_in = m;
        dual_slope_en  = mode;
        wr_en          = 1'b0;
        wr_chan        = '0;
        wr_data        = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NCH; i++) model_w[i] = '0;
        sb.delete();
    endtask

    task automatic write_ch(input int ch, input logic [BITS-1:0] d);
        wr_en   = 1'b1;
        wr_chan = ch[CHB-1:0];
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Returns at the first sample of the next period (count back at 0).
    task automatic wait_commit(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (period_end) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        ch_enable = '1;
        ch_invert = '1;
        apply_reset(11'd9, 1'b0);
        checks++;
        if (count !== 11'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (pwm_out !== 3'b000) begin
            errors++;
            $display("FAIL reset_pwm got %b want 000", pwm_out);
        end
        checks++;
        if (period_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_period_end got %b want 0", period_end);
        end
        ch_invert = '0;
    endtask

    task automatic test_sawtooth();
        bit ok;
        int highs;
        logic [BITS-1:0] ec;
        logic [NCH-1:0]  ep;
        apply_reset(11'd9, 1'b0);
        write_ch(0, 11'd3);
        wait_commit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL saw_commit got timeout want period_end");
        end
        model_w[0] = 11'd3;
        sb.delete();
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            ec = BITS'(k % 10);
            if (sb.size() > 0) begin
                ep = sb.pop_front();
                checks++;
                if (pwm_out !== ep) begin
                    errors++;
                    $display("FAIL saw_pwm k=%0d got %b want %b", k, pwm_out, ep);
                end
            end
            checks++;
            if (count !== ec) begin
                errors++;
                $display("FAIL saw_count k=%0d got %0d want %0d", k, count, ec);
            end
            checks++;
            if (period_end !== (ec == 11'd9)) begin
                errors++;
                $display("FAIL saw_period_end k=%0d got %b want %b", k, period_end, ec == 11'd9);
            end
            if (k >= 1 && k <= 10 && pwm_out[0]) highs++;
            sb.push_back(exp_pwm(ec));
            @(negedge clk);
        end
        checks++;
        if (highs !== 3) begin
            errors++;
            $display("FAIL saw_high_time got %0d want 3", highs);
        end
    endtask

    task automatic test_dual_slope();
        bit ok;
        int highs;
        logic [BITS-1:0] dseq [7] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd3, 11'd2, 11'd1};
        logic [BITS-1:0] ec;
        logic [NCH-1:0]  ep;
        apply_reset(11'd3, 1'b1);
        write_ch(0, 11'd2);
        wait_commit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dual_commit got timeout want period_end");
        end
        model_w[0] = 11'd2;
        sb.delete();
        highs = 0;
        for (int k = 0; k < 21; k++) begin
            ec = dseq[k % 7];
            if (sb.size() > 0) begin
                ep = sb.pop_front();
                checks++;
                if (pwm_out !== ep) begin
                    errors++;
                    $display("FAIL dual_pwm k=%0d got %b want %b", k, pwm_out, ep);
                end
            end
            checks++;
            if (count !== ec) begin
                errors++;
                $display("FAIL dual_count k=%0d got %0d want %0d", k, count, ec);
            end
            checks++;
            if (period_end !== ((k % 7) == 6)) begin
                errors++;
                $display("FAIL dual_period_end k=%0d got %b want %b", k, period_end, (k % 7) == 6);
            end
            if (k >= 1 && k <= 7 && pwm_out[0]) highs++;
            sb.push_back(exp_pwm(ec));
            @(negedge clk);
        end
        checks++;
        if (highs !== 3) begin
            errors++;
            $display("FAIL dual_high_time got %0d want 3", highs);
        end
    endtask

    task automatic test_update();
        bit ok;
        int h1, h2;
        logic [BITS-1:0] ec;
        logic [NCH-1:0]  ep;
        apply_reset(11'd9, 1'b0);
        wait_commit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL upd_commit got timeout want period_end");
        end
        sb.delete();
        h1 = 0;
        h2 = 0;
        for (int k = 0; k < 31; k++) begin
            ec = BITS'(k % 10);
            if (sb.size() > 0) begin
                ep = sb.pop_front();
                checks++;
                if (pwm_out !== ep) begin
                    errors++;
                    $display("FAIL upd_pwm k=%0d got %b want %b", k, pwm_out, ep);
                end
            end
            checks++;
            if (count !== ec) begin
                errors++;
                $display("FAIL upd_count k=%0d got %0d want %0d", k, count, ec);
            end
            if (k >= 11 && k <= 20 && pwm_out[1]) h1++;
            if (k >= 21 && k <= 30 && pwm_out[1]) h2++;
            // Two writes in one period (last wins), then one on the commit cycle.
            wr_en   = (k == 4) || (k == 5) || (k == 19);
            wr_chan = 2'd1;
            wr_data = (k == 4) ? 11'd7 : (k == 5) ? 11'd5 : 11'd2;
            sb.push_back(exp_pwm(ec));
            if (k == 9)  model_w[1] = 11'd5;
            if (k == 19) model_w[1] = 11'd2;
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++;
        if (h1 !== 5) begin
            errors++;
            $display("FAIL upd_high_time_5 got %0d want 5", h1);
        end
        checks++;
        if (h2 !== 2) begin
            errors++;
            $display("FAIL upd_high_time_writethrough got %0d want 2", h2);
        end
    endtask

    task automatic test_forced();
        bit ok;
        logic [NCH-1:0] en [4] = '{3'b111, 3'b111, 3'b000, 3'b101};
        logic [NCH-1:0] iv [4] = '{3'b000, 3'b111, 3'b101, 3'b010};
        logic [NCH-1:0] ep;
        apply_reset(11'd9, 1'b0);
        write_ch(0, 11'h400);
        write_ch(1, 11'h600);
        write_ch(2, 11'd12);
        wait_commit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL forced_commit got timeout want period_end");
        end
        model_w[0] = 11'h400;
        model_w[1] = 11'h600;
        model_w[2] = 11'd12;
        for (int c = 0; c < 4; c++) begin
            ch_enable = en[c];
            ch_invert = iv[c];
            sb.delete();
            for (int k = 0; k < 7; k++) begin
                if (sb.size() > 0) begin
                    ep = sb.pop_front();
                    checks++;
                    if (pwm_out !== ep) begin
                        errors++;
                        $display("FAIL forced_pwm combo=%0d k=%0d got %b want %b",
                                 c, k, pwm_out, ep);
                    end
                end
                // Count never exceeds M=9 here, so every width is count-independent.
                sb.push_back(exp_pwm(11'd0));
                @(negedge clk);
            end
        end
        ch_enable = '1;
        ch_invert = '0;
    endtask

    task automatic test_max_change();
        bit ok;
        int j;
        logic [BITS-1:0] ec;
        logic            epe;
        apply_reset(11'd9, 1'b0);
        wait_commit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL max_commit got timeout want period_end");
        end
        for (int k = 0; k < 34; k++) begin
            j = (k >= 15) ? (k - 15) % 9 : 0;
            if (k < 10)      ec = BITS'(k);
            else if (k < 15) ec = BITS'(k - 10);
            else             ec = (j <= 4) ? BITS'(j) : BITS'(9 - j);
            epe = (k == 9) || (k == 14) || (k >= 15 && j == 8);
            checks++;
            if (count !== ec) begin
                errors++;
                $display("FAIL max_count k=%0d got %0d want %0d", k, count, ec);
            end
            checks++;
            if (period_end !== epe) begin
                errors++;
                $display("FAIL max_period_end k=%0d got %b want %b", k, period_end, epe);
            end
            if (k == 7)  compare_max_in = 11'd4;
            if (k == 12) dual_slope_en = 1'b1;
            @(negedge clk);
        end
        compare_max_in = 11'd9;
        dual_slope_en  = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [BITS-1:0] ec;
        apply_reset(11'd9, 1'b0);
        write_ch(0, 11'd5);
        wait_commit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmid_commit got timeout want period_end");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 3'b001) begin
            errors++;
            $display("FAIL rmid_pre_pwm got %b want 001", pwm_out);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (count !== 11'd0) begin
            errors++;
            $display("FAIL rmid_count got %0d want 0", count);
        end
        checks++;
        if (pwm_out !== 3'b000) begin
            errors++;
            $display("FAIL rmid_pwm got %b want 000", pwm_out);
        end
        // Widths (shadow included) are cleared, so outputs stay low across a commit.
        for (int k = 0; k < 12; k++) begin
            ec = BITS'(k % 10);
            checks++;
            if (count !== ec || pwm_out !== 3'b000) begin
                errors++;
                $display("FAIL rmid_after k=%0d got count %0d pwm %b want count %0d pwm 000",
                         k, count, pwm_out, ec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_chan();
        bit ok;
        logic [BITS-1:0] ec;
        logic [NCH-1:0]  ep;
        apply_reset(11'd9, 1'b0);
        write_ch(3, 11'h400);
        write_ch(0, 11'd4);
        write_ch(3, 11'd8);
        wait_commit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bad_commit got timeout want period_end");
        end
        model_w[0] = 11'd4;
        sb.delete();
        for (int k = 0; k < 12; k++) begin
            ec = BITS'(k % 10);
            if (sb.size() > 0) begin
                ep = sb.pop_front();
                checks++;
                if (pwm_out !== ep) begin
                    errors++;
                    $display("FAIL bad_chan_pwm k=%0d got %b want %b", k, pwm_out, ep);
                end
            end
            sb.push_back(exp_pwm(ec));
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        dual_slope_en  = 1'b0;
        compare_max_in = 11'd9;
        wr_en          = 1'b0;
        wr_chan        = '0;
        wr_data        = '0;
        ch_enable      = '1;
        ch_invert      = '0;
        test_reset();
        test_sawtooth();
        test_dual_slope();
        test_update();
        test_forced();
        test_max_change();
        test_reset_mid();
        test_bad_chan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
